// File: rtl/kbd_pkg.sv
// Shared constants and lookup functions for the keyboard / 7-seg / LED peripheral.
// Holds the 7-seg font and the set-2 scancode to ASCII table.
package kbd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] BREAK     = 8'hF0;
  localparam logic [7:0] EXT       = 8'hE0;

  // active-low a..g in bits 0..6, dp off
  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] scan2ascii(input logic [7:0] sc);
    logic [7:0] a;
    case (sc)
      8'h1C: a = 8'h41;
      8'h32: a = 8'h42;
      8'h21: a = 8'h43;
      8'h23: a = 8'h44;
      8'h24: a = 8'h45;
      8'h2B: a = 8'h46;
      8'h34: a = 8'h47;
      8'h33: a = 8'h48;
      8'h43: a = 8'h49;
      8'h3B: a = 8'h4A;
      8'h42: a = 8'h4B;
      8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D;
      8'h31: a = 8'h4E;
      8'h44: a = 8'h4F;
      8'h4D: a = 8'h50;
      8'h15: a = 8'h51;
      8'h2D: a = 8'h52;
      8'h1B: a = 8'h53;
      8'h2C: a = 8'h54;
      8'h3C: a = 8'h55;
      8'h2A: a = 8'h56;
      8'h1D: a = 8'h57;
      8'h22: a = 8'h58;
      8'h35: a = 8'h59;
      8'h1A: a = 8'h5A;
      8'h45: a = 8'h30;
      8'h16: a = 8'h31;
      8'h1E: a = 8'h32;
      8'h26: a = 8'h33;
      8'h25: a = 8'h34;
      8'h2E: a = 8'h35;
      8'h36: a = 8'h36;
      8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;
      8'h46: a = 8'h39;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/kbd_seg_led_if.sv
// Received-byte stream from the PS/2 receiver to the key tracker.
// One-cycle valid strobe qualifies code.
interface kbd_seg_led_if;
  import kbd_pkg::*;

  logic [7:0] code;
  logic       valid;

  modport master (output code, valid);
  modport slave  (input  code, valid);

endinterface

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchroniser, 11-bit frame shifter, framing/parity check
// and mid-frame idle timeout.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int PS2_TIMEOUT = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  kbd_seg_led_if.master rx
);

  localparam int TW = $clog2(PS2_TIMEOUT + 1);

  logic [2:0]    clk_s;
  logic [2:0]    dat_s;
  logic [3:0]    bitcnt;
  logic [10:0]   sreg;
  logic          done;
  logic [TW-1:0] idle;
  logic          fall;

  assign fall = clk_s[2] & ~clk_s[1];

  // frame in sreg: [0] start, [8:1] data, [9] parity, [10] stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s    <= '0;
      dat_s    <= '0;
      bitcnt   <= '0;
      sreg     <= '0;
      done     <= 1'b0;
      idle     <= '0;
      rx.code  <= '0;
      rx.valid <= 1'b0;
    end else begin
      clk_s    <= {clk_s[1:0], ps2_clk};
      dat_s    <= {dat_s[1:0], ps2_data};
      done     <= 1'b0;
      rx.valid <= 1'b0;
      if (fall) begin
        sreg <= {dat_s[2], sreg[10:1]};
        idle <= '0;
        if (bitcnt == 4'd10) begin
          bitcnt <= '0;
          done   <= 1'b1;
        end else begin
          bitcnt <= bitcnt + 4'd1;
        end
      end else if (bitcnt != 4'd0) begin
        if (idle == TW'(PS2_TIMEOUT - 1)) begin
          bitcnt <= '0;
          idle   <= '0;
        end else begin
          idle <= idle + TW'(1);
        end
      end
      if (done) begin
        rx.code  <= sreg[8:1];
        rx.valid <= ~sreg[0] & sreg[10] & (^sreg[9:1]);
      end
    end
  end

endmodule

// File: rtl/kbd_seg_led.sv
// Board I/O peripheral: PS/2 key display on eight 7-seg digits and a
// rotating LED pattern mixed with the slide switches.
module kbd_seg_led
  import kbd_pkg::*;
#(
  parameter int LED_DIV     = 5_000_000,
  parameter int PS2_TIMEOUT = 50_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  sw,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] ledr,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7
);

  localparam int DW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;

  kbd_seg_led_if rx_bus ();

  ps2_rx #(.PS2_TIMEOUT(PS2_TIMEOUT)) u_rx (
    .clk      (clk),
    .rst_n    (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (rx_bus.master)
  );

  logic [DW-1:0] div;
  logic [15:0]   pat;
  logic [7:0]    scancode;
  logic          pressed;
  logic          break_flag;
  logic [7:0]    count;
  logic [7:0]    asc;
  logic          is_brk;
  logic          is_ext;
  logic          is_rel;
  logic          is_make;

  assign ledr    = {pat[15:10], pat[9:0] ^ sw};
  assign asc     = scan2ascii(scancode);
  assign is_brk  = rx_bus.code == BREAK;
  assign is_ext  = rx_bus.code == EXT;
  assign is_rel  = ~is_brk & ~is_ext & break_flag;
  assign is_make = ~is_brk & ~is_ext & ~break_flag;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div <= '0;
      pat <= 16'h0001;
    end else if (div == DW'(LED_DIV - 1)) begin
      div <= '0;
      pat <= {pat[14:0], pat[15]};
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scancode   <= '0;
      pressed    <= 1'b0;
      break_flag <= 1'b0;
      count      <= '0;
    end else if (rx_bus.valid) begin
      unique case (1'b1)
        is_brk: break_flag <= 1'b1;
        is_ext: ;
        is_rel: begin
          pressed    <= 1'b0;
          break_flag <= 1'b0;
        end
        is_make: begin
          // held-key repeats do not bump the count
          if (!pressed || rx_bus.code != scancode)
            count <= count + 8'd1;
          scancode <= rx_bus.code;
          pressed  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg0 <= SEG_BLANK;
      seg1 <= SEG_BLANK;
      seg2 <= SEG_BLANK;
      seg3 <= SEG_BLANK;
      seg4 <= SEG_BLANK;
      seg5 <= SEG_BLANK;
      seg6 <= SEG_BLANK;
      seg7 <= SEG_BLANK;
    end else begin
      seg0 <= pressed ? hex7(scancode[3:0]) : SEG_BLANK;
      seg1 <= pressed ? hex7(scancode[7:4]) : SEG_BLANK;
      seg2 <= (pressed && asc != 8'h00) ? hex7(asc[3:0]) : SEG_BLANK;
      seg3 <= (pressed && asc != 8'h00) ? hex7(asc[7:4]) : SEG_BLANK;
      seg4 <= SEG_BLANK;
      seg5 <= SEG_BLANK;
      seg6 <= hex7(count[3:0]);
      seg7 <= hex7(count[7:4]);
    end
  end

endmodule

// File: tb/tb_kbd_seg_led.sv
// Bench for kbd_seg_led: PS/2 frames driven bit by bit, display and LEDs
// compared against a behavioural key/LED model.
`timescale 1ns/1ps
module tb_kbd_seg_led;

  localparam int LED_DIV = 4;
  localparam int TMO     = 200;
  localparam int H       = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  sw;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] ledr;
  logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  kbd_seg_led_if exp_bus ();

  kbd_seg_led #(.LED_DIV(LED_DIV), .PS2_TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .sw(sw),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ledr(ledr),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
  );

  always #5 clk = ~clk;

  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                               8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                               8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                              8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // reference key state
  logic [7:0] m_sc;
  logic       m_pr;
  logic       m_brk;
  logic [7:0] m_cnt;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_sc  <= 8'h00;
      m_pr  <= 1'b0;
      m_brk <= 1'b0;
      m_cnt <= 8'h00;
    end else if (exp_bus.valid) begin
      if (exp_bus.code == 8'hF0) begin
        m_brk <= 1'b1;
      end else if (exp_bus.code == 8'hE0) begin
        m_brk <= m_brk;
      end else if (m_brk) begin
        m_pr  <= 1'b0;
        m_brk <= 1'b0;
      end else begin
        if (!m_pr || exp_bus.code != m_sc) m_cnt <= m_cnt + 8'd1;
        m_sc <= exp_bus.code;
        m_pr <= 1'b1;
      end
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic logic [7:0] ascii_of(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (letters[i] == b) return 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) if (digits[i] == b) return 8'h30 + 8'(i);
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0]  a;
    logic [15:0] p;
    a = ascii_of(m_sc);
    p = 16'(1) << ((cyc / LED_DIV) % 16);
    chk({tag, ".seg0"}, 16'(seg0), 16'(m_pr ? font[m_sc[3:0]] : 8'hFF));
    chk({tag, ".seg1"}, 16'(seg1), 16'(m_pr ? font[m_sc[7:4]] : 8'hFF));
    chk({tag, ".seg2"}, 16'(seg2), 16'((m_pr && a != 0) ? font[a[3:0]] : 8'hFF));
    chk({tag, ".seg3"}, 16'(seg3), 16'((m_pr && a != 0) ? font[a[7:4]] : 8'hFF));
    chk({tag, ".seg4"}, 16'(seg4), 16'h00FF);
    chk({tag, ".seg5"}, 16'(seg5), 16'h00FF);
    chk({tag, ".seg6"}, 16'(seg6), 16'(font[m_cnt[3:0]]));
    chk({tag, ".seg7"}, 16'(seg7), 16'(font[m_cnt[7:4]]));
    chk({tag, ".ledr"}, ledr, {p[15:10], p[9:0] ^ sw});
  endtask

  task automatic settle_check(input string tag);
    repeat (12) @(negedge clk);
    sw = 10'($urandom);
    #1;
    check_all(tag);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits == 11 && !bad) begin
      exp_bus.code  = d;
      exp_bus.valid = 1'b1;
      @(negedge clk);
      exp_bus.valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst.seg0", 16'(seg0), 16'h00FF);
    chk("rst.seg7", 16'(seg7), 16'h00FF);
    chk("rst.ledr", ledr, {6'd0, 10'h001 ^ sw});
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] pool [8] = '{8'h1C, 8'h1C, 8'h45, 8'h32, 8'h16, 8'hF0, 8'hE0, 8'h2B};

  initial begin
    exp_bus.code  = 8'h00;
    exp_bus.valid = 1'b0;
    resetn   = 1'b0;
    sw       = 10'h000;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("init.seg0", 16'(seg0), 16'h00FF);
    chk("init.seg6", 16'(seg6), 16'h00FF);
    chk("init.ledr", ledr, 16'h0001);

    @(negedge clk);
    resetn = 1'b1;
    sw = 10'h3FF;
    repeat (4) @(negedge clk);
    #1;
    chk("led4", ledr, 16'h03FD);
    #2;
    resetn = 1'b0;
    #1;
    chk("led_rst", ledr, 16'h03FE);
    chk("led_rst.seg6", 16'(seg6), 16'h00FF);
    @(negedge clk);
    resetn = 1'b1;
    sw = 10'h000;
    repeat (3) @(negedge clk);
    #1;
    chk("idle.seg7", 16'(seg7), 16'h00C0);
    chk("idle.seg6", 16'(seg6), 16'h00C0);
    check_all("idle");

    send_frame(8'h1C, 1'b0, 11);
    settle_check("k1c");
    chk("k1c.seg1", 16'(seg1), 16'h00F9);
    chk("k1c.seg0", 16'(seg0), 16'h00C6);
    chk("k1c.seg3", 16'(seg3), 16'h0099);
    chk("k1c.seg6", 16'(seg6), 16'h00F9);

    for (int i = 0; i < 3; i++) begin
      send_frame(8'h1C, 1'b0, 11);
      settle_check("rep");
    end
    chk("rep.seg6", 16'(seg6), 16'h00F9);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    settle_check("brk");
    chk("brk.seg0", 16'(seg0), 16'h00FF);
    chk("brk.seg3", 16'(seg3), 16'h00FF);

    send_frame(8'h1C, 1'b1, 11);
    settle_check("par");
    chk("par.seg6", 16'(seg6), 16'h00F9);

    send_frame(8'h1C, 1'b0, 5);
    repeat (TMO + 50) @(negedge clk);
    send_frame(8'h45, 1'b0, 11);
    settle_check("tmo");
    chk("tmo.seg1", 16'(seg1), 16'h0099);
    chk("tmo.seg0", 16'(seg0), 16'h0092);
    chk("tmo.seg3", 16'(seg3), 16'h00B0);
    chk("tmo.seg2", 16'(seg2), 16'h00C0);

    send_frame(8'h1C, 1'b0, 6);
    do_reset();
    send_frame(8'h32, 1'b0, 11);
    settle_check("midrst");
    chk("midrst.seg1", 16'(seg1), 16'h00B0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) begin
        send_frame(8'($urandom), 1'b0, $urandom_range(1, 9));
        repeat (TMO + 30) @(negedge clk);
      end
      send_frame(b, $urandom_range(0, 7) == 0, 11);
      settle_check("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
